// File: rtl/gfx_fb_arbiter.sv
// gfx_fb_arbiter
// Framebuffer SRAM port arbiter between a display fetch (read) client and a
// pattern write client. Reads have priority; the memory-side request is a
// registered valid/ready slot, and read responses are forwarded in order one
// cycle after they arrive.
// Optional feature macro: GFX_FB_ARB_STARVE_GUARD_EN -- when defined, a write
// is forced through after STARVE_MAX consecutive read grants seen by a waiting
// writer. When undefined, strict read priority applies.

module gfx_fb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned MAX_RD_OUT = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // display fetch client
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   // pattern write client
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   // memory side
   output logic                  m_valid,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic                  m_ready,
   input  logic                  m_rdata_valid,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   // status
   output logic                  err
);

   // Reject parameter values outside the supported ranges at elaboration.
   if (MAX_RD_OUT == 0 || MAX_RD_OUT > 15 || STARVE_MAX == 0 || STARVE_MAX > 255) begin : g_bad_params
      $error("gfx_fb_arbiter: MAX_RD_OUT must be 1..15 and STARVE_MAX 1..255");
   end

   localparam logic [3:0] LP_MAX_RD = 4'(MAX_RD_OUT);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } grant_e;

   logic                  r_m_valid;
   logic                  r_m_we;
   logic [ADDR_WIDTH-1:0] r_m_addr;
   logic [DATA_WIDTH-1:0] r_m_wdata;
   logic                  r_rd_data_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_err;
   logic [3:0]            r_rd_out;

   logic   w_slot_free;
   logic   w_rd_elig;
   logic   w_force_wr;
   logic   w_rd_acc;
   logic   w_wr_acc;
   grant_e w_grant;

   assign w_slot_free = !r_m_valid || m_ready;
   assign w_rd_elig   = rd_valid && w_slot_free && (r_rd_out < LP_MAX_RD);

`ifdef GFX_FB_ARB_STARVE_GUARD_EN
   localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

   logic [7:0] r_starve;

   // Count read grants taken while a writer waits; any write grant or idle writer restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (!wr_valid || w_wr_acc) begin
         r_starve <= '0;
      end else if (w_rd_acc && (r_starve != '1)) begin
         r_starve <= r_starve + 8'd1;
      end
   end

   assign w_force_wr = (r_starve == LP_STARVE_MAX);
`else
   assign w_force_wr = 1'b0;
`endif

   // Grant selection: read first unless the write is forced; nothing is granted in reset.
   always_comb begin
      w_grant = GNT_NONE;
      if (rst_n && w_slot_free) begin
         if (wr_valid && (!w_rd_elig || w_force_wr)) begin
            w_grant = GNT_WR;
         end else if (w_rd_elig) begin
            w_grant = GNT_RD;
         end
      end
   end

   assign w_rd_acc = (w_grant == GNT_RD);
   assign w_wr_acc = (w_grant == GNT_WR);
   assign rd_ready = w_rd_acc;
   assign wr_ready = w_wr_acc;

   // Memory request slot: load on grant, drop valid when free and idle, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
      end else begin
         case (w_grant)
            GNT_RD: begin
               r_m_valid <= 1'b1;
               r_m_we    <= 1'b0;
               r_m_addr  <= rd_addr;
            end
            GNT_WR: begin
               r_m_valid <= 1'b1;
               r_m_we    <= 1'b1;
               r_m_addr  <= wr_addr;
               r_m_wdata <= wr_data;
            end
            default: begin
               if (w_slot_free) begin
                  r_m_valid <= 1'b0;
               end
            end
         endcase
      end
   end

   // Outstanding read count; a response with nothing outstanding leaves it at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_out <= '0;
      end else if (w_rd_acc && !m_rdata_valid) begin
         r_rd_out <= r_rd_out + 4'd1;
      end else if (!w_rd_acc && m_rdata_valid && (r_rd_out != '0)) begin
         r_rd_out <= r_rd_out - 4'd1;
      end
   end

   // Sticky error on an unsolicited read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (m_rdata_valid && (r_rd_out == '0)) begin
         r_err <= 1'b1;
      end
   end

   // Forward read responses one cycle later, unconditionally and in arrival order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data_valid <= 1'b0;
         r_rd_data       <= '0;
      end else begin
         r_rd_data_valid <= m_rdata_valid;
         r_rd_data       <= m_rdata;
      end
   end

   assign m_valid       = r_m_valid;
   assign m_we          = r_m_we;
   assign m_addr        = r_m_addr;
   assign m_wdata       = r_m_wdata;
   assign rd_data_valid = r_rd_data_valid;
   assign rd_data       = r_rd_data;
   assign err           = r_err;

endmodule

// File: tb/tb_gfx_fb_arbiter.sv
// Self-checking bench for gfx_fb_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
// Honors GFX_FB_ARB_STARVE_GUARD_EN when the bench is built with it.

module tb_gfx_fb_arbiter;

   localparam int unsigned AW    = 20;
   localparam int unsigned DW    = 12;
   localparam int          MAXRD = 4;
   localparam int          SMAX  = 8;
`ifdef GFX_FB_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_valid, rd_ready, rd_data_valid;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          m_valid, m_we, m_ready, m_rdata_valid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic          err;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          e_mv, e_we, e_rdv, e_err, e_rd_ready, e_wr_ready;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;
   int          e_rd_out, e_starve, e_xfer_rd;

   gfx_fb_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_RD_OUT (MAXRD),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .m_valid       (m_valid),
      .m_we          (m_we),
      .m_addr        (m_addr),
      .m_wdata       (m_wdata),
      .m_ready       (m_ready),
      .m_rdata_valid (m_rdata_valid),
      .m_rdata       (m_rdata),
      .err           (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      e_mv = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_rdv = 0; e_rdata = '0; e_err = 0;
      e_rd_out = 0; e_starve = 0; e_xfer_rd = 0;
   endtask

   // Who should be granted this cycle, from the arbitration rules.
   task automatic model_ready();
      bit free, elig, force_w;
      free    = !e_mv || m_ready;
      elig    = rd_valid && free && (e_rd_out < MAXRD);
      force_w = GUARD && (e_starve == SMAX);
      e_wr_ready = wr_valid && free && (!elig || force_w);
      e_rd_ready = elig && !e_wr_ready;
   endtask

   // Advance one clock, updating the model from the inputs held this cycle.
   task automatic tick();
      bit            free, n_mv, n_we, n_err;
      logic [AW-1:0] n_addr;
      logic [DW-1:0] n_wdata;
      int            n_rd_out, n_starve, n_xfer;
      model_ready();
      free = !e_mv || m_ready;
      n_mv = e_mv; n_we = e_we; n_addr = e_addr; n_wdata = e_wdata;
      if (e_rd_ready) begin
         n_mv = 1; n_we = 0; n_addr = rd_addr;
      end else if (e_wr_ready) begin
         n_mv = 1; n_we = 1; n_addr = wr_addr; n_wdata = wr_data;
      end else if (free) begin
         n_mv = 0;
      end
      n_err    = e_err || (m_rdata_valid && e_rd_out == 0);
      n_rd_out = e_rd_out + (e_rd_ready ? 1 : 0) - (m_rdata_valid ? 1 : 0);
      if (n_rd_out < 0) n_rd_out = 0;
      if (!wr_valid || e_wr_ready) n_starve = 0;
      else if (e_rd_ready && e_starve < 255) n_starve = e_starve + 1;
      else n_starve = e_starve;
      n_xfer = e_xfer_rd + ((e_mv && m_ready && !e_we) ? 1 : 0);
      if (m_rdata_valid && n_xfer > 0) n_xfer = n_xfer - 1;
      e_rdv   = m_rdata_valid;
      e_rdata = m_rdata;
      @(posedge clk);
      #1;
      e_mv = n_mv; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
      e_err = n_err; e_rd_out = n_rd_out; e_starve = n_starve; e_xfer_rd = n_xfer;
   endtask

   task automatic idle_inputs();
      rd_valid = 0; wr_valid = 0; m_rdata_valid = 0; m_ready = 1;
      rd_addr = '0; wr_addr = '0; wr_data = '0; m_rdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      rd_valid = 1; wr_valid = 1; m_ready = 1; m_rdata_valid = 1;
      rd_addr = 20'h12345; wr_addr = 20'h54321; wr_data = 12'hFFF; m_rdata = 12'h777;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err} !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h exp 0", {m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err});
      end
      checks++;
      if ({rd_ready, wr_ready} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b exp 00", {rd_ready, wr_ready});
      end
      idle_inputs();
      rst_n = 1;
      model_reset();
      #2;
   endtask

   task automatic test_read_basic();
      rd_valid = 1; rd_addr = 20'h00010; m_ready = 1;
      #2;
      checks++;
      if ({rd_ready, wr_ready} !== 2'b10) begin
         errors++;
         $display("FAIL rd_basic_accept: got %b exp 10", {rd_ready, wr_ready});
      end
      tick();
      rd_valid = 0;
      #2;
      checks++;
      if ({m_valid, m_we, m_addr} !== {1'b1, 1'b0, 20'h00010}) begin
         errors++;
         $display("FAIL rd_basic_mreq: got %h exp %h", {m_valid, m_we, m_addr}, {1'b1, 1'b0, 20'h00010});
      end
      m_rdata_valid = 1; m_rdata = 12'hABC;
      tick();
      m_rdata_valid = 0;
      #2;
      checks++;
      if ({rd_data_valid, rd_data, m_valid} !== {1'b1, 12'hABC, 1'b0}) begin
         errors++;
         $display("FAIL rd_basic_resp: got %h exp %h", {rd_data_valid, rd_data, m_valid}, {1'b1, 12'hABC, 1'b0});
      end
   endtask

   task automatic test_stall();
      wr_valid = 1; wr_addr = 20'h00020; wr_data = 12'h5A5; m_ready = 0; rd_valid = 0;
      #2;
      checks++;
      if ({rd_ready, wr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL stall_wr_accept: got %b exp 01", {rd_ready, wr_ready});
      end
      tick();
      rd_valid = 1; rd_addr = 20'h00099; wr_addr = 20'h00077; wr_data = 12'h111;
      for (int i = 0; i < 5; i++) begin
         #2;
         checks++;
         if ({m_valid, m_we, m_addr, m_wdata, rd_ready, wr_ready} !==
             {1'b1, 1'b1, 20'h00020, 12'h5A5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got %h exp %h", i,
                     {m_valid, m_we, m_addr, m_wdata, rd_ready, wr_ready},
                     {1'b1, 1'b1, 20'h00020, 12'h5A5, 1'b0, 1'b0});
         end
         tick();
      end
      rd_valid = 0; wr_valid = 0; m_ready = 1;
      tick();
      #2;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got %b exp 0", m_valid);
      end
   endtask

   task automatic test_max_outstanding();
      m_ready = 1; wr_valid = 0;
      for (int i = 0; i < MAXRD; i++) begin
         rd_valid = 1; rd_addr = 20'h00100 + 20'(i);
         #2;
         checks++;
         if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL maxrd_accept[%0d]: got %b exp 1", i, rd_ready);
         end
         tick();
      end
      wr_valid = 1; wr_addr = 20'h00030; wr_data = 12'h3C3;
      #2;
      checks++;
      if ({rd_ready, wr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL maxrd_block_rd_wr_ok: got %b exp 01", {rd_ready, wr_ready});
      end
      tick();
      wr_valid = 0;
      #2;
      checks++;
      if ({rd_ready, m_valid, m_we, m_addr, m_wdata} !== {1'b0, 1'b1, 1'b1, 20'h00030, 12'h3C3}) begin
         errors++;
         $display("FAIL maxrd_write_out: got %h exp %h", {rd_ready, m_valid, m_we, m_addr, m_wdata},
                  {1'b0, 1'b1, 1'b1, 20'h00030, 12'h3C3});
      end
      m_rdata_valid = 1; m_rdata = 12'h444;
      tick();
      m_rdata_valid = 0;
      #2;
      checks++;
      if (rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL maxrd_reopen: got %b exp 1", rd_ready);
      end
      rd_valid = 0;
      tick();
      for (int i = 0; i < 8 && e_rd_out > 0; i++) begin
         m_rdata_valid = 1; m_rdata = 12'(i);
         tick();
      end
      m_rdata_valid = 0;
      tick();
   endtask

   task automatic test_starve();
      bit exp_w;
      rd_valid = 1; wr_valid = 1; m_ready = 1;
      for (int c = 0; c < 36; c++) begin
         rd_addr = 20'($urandom); wr_addr = 20'($urandom); wr_data = 12'($urandom);
         m_rdata_valid = (e_xfer_rd > 0); m_rdata = 12'($urandom);
         #2;
         exp_w = GUARD && ((c % (SMAX + 1)) == SMAX);
         checks++;
         if ({rd_ready, wr_ready} !== {!exp_w, exp_w}) begin
            errors++;
            $display("FAIL starve_grant[%0d]: got %b exp %b", c, {rd_ready, wr_ready}, {!exp_w, exp_w});
         end
         checks++;
         if ({rd_data_valid, rd_data} !== {e_rdv, e_rdata}) begin
            errors++;
            $display("FAIL starve_rdata[%0d]: got %h exp %h", c, {rd_data_valid, rd_data}, {e_rdv, e_rdata});
         end
         tick();
      end
      rd_valid = 0; wr_valid = 0;
      for (int i = 0; i < 10; i++) begin
         m_rdata_valid = (e_rd_out > 0);
         tick();
      end
      m_rdata_valid = 0;
   endtask

   task automatic test_err_and_reset();
      m_rdata_valid = 1; m_rdata = 12'h123;
      #2;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got %b exp 0", err);
      end
      tick();
      m_rdata_valid = 0;
      #2;
      checks++;
      if ({err, rd_data_valid, rd_data} !== {1'b1, 1'b1, 12'h123}) begin
         errors++;
         $display("FAIL err_set_fwd: got %h exp %h", {err, rd_data_valid, rd_data}, {1'b1, 1'b1, 12'h123});
      end
      repeat (3) tick();
      rd_valid = 1; rd_addr = 20'h00055;
      #2;
      checks++;
      if ({err, rd_ready} !== 2'b11) begin
         errors++;
         $display("FAIL err_sticky_no_underflow: got %b exp 11", {err, rd_ready});
      end
      tick();
      rd_addr = 20'h00056;
      tick();
      // reset asserted mid-burst, away from the clock edge
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err, rd_ready, wr_ready} !== '0) begin
         errors++;
         $display("FAIL async_reset: got %h exp 0",
                  {m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err, rd_ready, wr_ready});
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
      rd_valid = 1; m_ready = 1;
      for (int i = 0; i < MAXRD; i++) begin
         rd_addr = 20'h00200 + 20'(i);
         #2;
         checks++;
         if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_rd_out[%0d]: got %b exp 1", i, rd_ready);
         end
         tick();
      end
      #2;
      checks++;
      if ({rd_ready, err} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_full: got %b exp 00", {rd_ready, err});
      end
      rd_valid = 0;
      for (int i = 0; i < 10; i++) begin
         m_rdata_valid = (e_rd_out > 0);
         tick();
      end
      m_rdata_valid = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rd_valid = ($urandom_range(0, 9) < 6);
         wr_valid = ($urandom_range(0, 9) < 5);
         rd_addr  = 20'($urandom);
         wr_addr  = 20'($urandom);
         wr_data  = 12'($urandom);
         m_ready  = ($urandom_range(0, 3) != 0);
         m_rdata_valid = (e_xfer_rd > 0) && ($urandom_range(0, 1) == 1);
         m_rdata  = 12'($urandom);
         #2;
         model_ready();
         checks++;
         if ({rd_ready, wr_ready} !== {e_rd_ready, e_wr_ready}) begin
            errors++;
            $display("FAIL rand_grant[%0d]: got %b exp %b", c, {rd_ready, wr_ready}, {e_rd_ready, e_wr_ready});
         end
         checks++;
         if ({m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err} !==
             {e_mv, e_we, e_addr, e_wdata, e_rdv, e_rdata, e_err}) begin
            errors++;
            $display("FAIL rand_regs[%0d]: got %h exp %h", c,
                     {m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err},
                     {e_mv, e_we, e_addr, e_wdata, e_rdv, e_rdata, e_err});
         end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      test_reset();
      test_read_basic();
      test_stall();
      test_max_outstanding();
      test_starve();
      test_err_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gfx_fb_arbiter.md
GFX_FB_ARBITER -- requirements
Module: gfx_fb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, SRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 12, pixel data width.
REQ-003 Parameter MAX_RD_OUT, default 4, maximum reads in flight (range 1..15).
REQ-004 Parameter STARVE_MAX, default 8, consecutive read grants before a forced write (range 1..255).
REQ-005 The block SHALL have a single clock, clk (input, 1), which clocks all sequential logic; the block SHALL have reset rst_n (input, 1), asynchronous, active-low.
REQ-006 Port rd_valid, input, 1: display fetch request.
REQ-007 Port rd_ready, output, 1: fetch request accepted.
REQ-008 Port rd_addr, input, ADDR_WIDTH: fetch address.
REQ-009 Port rd_data_valid, output, 1: fetch response valid.
REQ-010 Port rd_data, output, DATA_WIDTH: fetch response data.
REQ-011 Port wr_valid, input, 1: pattern write request.
REQ-012 Port wr_ready, output, 1: write request accepted.
REQ-013 Port wr_addr, input, ADDR_WIDTH: write address.
REQ-014 Port wr_data, input, DATA_WIDTH: write data.
REQ-015 Memory-side outputs: m_valid (1), m_we (1), m_addr (ADDR_WIDTH), m_wdata (DATA_WIDTH).
REQ-016 Memory-side inputs: m_ready (1), m_rdata_valid (1), m_rdata (DATA_WIDTH).
REQ-017 Port err, output, 1: sticky protocol error.

Function
REQ-018 The memory-side outputs SHALL be registered, and a transfer SHALL occur on m_valid && m_ready.
REQ-019 The output slot is free when !m_valid || m_ready.
- A request accepted in cycle N SHALL appear on m_valid in cycle N+1.
- m_valid/m_we/m_addr/m_wdata SHALL hold stable while m_valid && !m_ready.
REQ-020 Read eligibility: rd_valid && slot free && (rd_out < MAX_RD_OUT), where rd_out is the outstanding-read count.
REQ-021 Grant rule: read has priority over write; a write SHALL be granted only when wr_valid && slot free && the read is not eligible (or a write is forced per REQ-031).
REQ-022 rd_ready and wr_ready SHALL be combinational, mutually exclusive, and never both high.
REQ-023 On read accept, the block SHALL load m_we=0 and m_addr=rd_addr; on write accept, it SHALL load m_we=1, m_addr=wr_addr, m_wdata=wr_data.
REQ-024 When the slot is free and neither request is accepted, m_valid SHALL go 0 next cycle.
REQ-025 rd_out SHALL be 4 bits:
- +1 on read accept;
- -1 on m_rdata_valid;
- unchanged when both occur in the same cycle.
REQ-026 When rd_out == MAX_RD_OUT, rd_ready SHALL be 0 and writes MAY proceed.
REQ-027 rd_data_valid/rd_data SHALL equal m_rdata_valid/m_rdata registered by one cycle, in order, with no reordering.
REQ-028 m_rdata_valid while rd_out == 0 SHALL set err; rd_out SHALL stay 0 (no underflow), and the data SHALL still be forwarded.
REQ-029 err SHALL clear only on reset.

Reset
REQ-030 While rst_n=0, all of the following SHALL be 0 immediately (asynchronously): m_valid, m_we, m_addr, m_wdata, rd_data_valid, rd_data, err, rd_out and the starve counter. A transfer in progress at reset SHALL be dropped without completion, and rd_ready/wr_ready SHALL be 0.

Configuration
REQ-031 With macro GFX_FB_ARB_STARVE_GUARD_EN defined, an 8-bit starve counter SHALL apply:
- it SHALL increment on each read grant while wr_valid=1;
- it SHALL clear on any write grant or on any cycle with wr_valid=0;
- when it equals STARVE_MAX, the next free slot SHALL grant the write over an eligible read.
REQ-032 Without GFX_FB_ARB_STARVE_GUARD_EN, the block SHALL apply strict read priority, and no starve counter SHALL exist.

Verification
REQ-033 rd_valid=1 at addr 0x00010, m_ready=1 -> m_valid=1, m_we=0, m_addr=0x00010 one cycle after accept; m_rdata_valid with 0xABC -> rd_data=0xABC one cycle later.
REQ-034 m_ready=0 for 5 cycles with a write pending (addr 0x00020, data 0x5A5) -> the m_* outputs stay constant and rd_ready=wr_ready=0 throughout.
REQ-035 4 reads accepted with no responses (MAX_RD_OUT=4) -> rd_ready=0; a pending write is granted; 1 response -> rd_ready=1 again.
REQ-036 With the macro defined, rd_valid=wr_valid=1 held continuously (STARVE_MAX=8) -> pattern of 8 reads then 1 write, repeating; without the macro -> no write is ever granted.
REQ-037 m_rdata_valid pulse with rd_out=0 -> err=1, held until reset; rst_n low mid-burst -> all outputs 0 the same cycle and rd_out=0 after release.
